// File: rtl/demux1_4.sv
// Registered 1-to-4 stream demultiplexer: one valid/ready input fanned out to
// four one-entry lane slices, steered by an explicit select or a round-robin pointer.
module demux1_4 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             mode,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       rr_ptr,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       tgt;
  logic             accept;
  logic [3:0]       fill;
  logic [3:0]       drain;
  logic [WIDTH-1:0] lane_data [4];

  assign tgt = mode ? rr_ptr : select;

  // A full lane that is draining this cycle may be refilled in the same cycle.
  assign in_ready = !clr && rst_n && (!out_valid[tgt] || out_ready[tgt]);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid & out_ready;

  // NOTE: default every combinational output before the conditional write,
  // otherwise the untouched bits would hold their value and infer a latch.
  always_comb begin
    fill = 4'b0000;
    if (accept) fill[tgt] = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the lane data registers are small and must read zero out of reset,
      // so they are reset along with the control state.
      for (int i = 0; i < 4; i++) lane_data[i] <= '0;
      out_valid <= 4'b0000;
      rr_ptr    <= 2'd0;
      beat_cnt  <= '0;
    end else begin
      // accept is already blocked by clr, so data loads need no clr term.
      for (int i = 0; i < 4; i++) begin
        if (fill[i]) lane_data[i] <= in_data;
      end

      if (clr) begin
        out_valid <= 4'b0000;
        rr_ptr    <= 2'd0;
        beat_cnt  <= '0;
      end else begin
        out_valid <= fill | (out_valid & ~drain);
        if (accept && mode) rr_ptr <= rr_ptr + 2'd1;
        if (accept) beat_cnt <= beat_cnt + CNT_ONE;
      end
    end
  end

  assign out_0 = lane_data[0];
  assign out_1 = lane_data[1];
  assign out_2 = lane_data[2];
  assign out_3 = lane_data[3];

endmodule
